// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle ARM controller and its datapath.
// The controller drives the master side; the datapath (or a bench) drives the slave side.
interface multicycle_controller_if;
   logic [19:0] Instr;
   logic [3:0]  ALUFlags;
   logic        PCWrite;
   logic        MemWrite;
   logic        RegWrite;
   logic        IRWrite;
   logic        AdrSrc;
   logic [1:0]  ResultSrc;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  ImmSrc;
   logic [1:0]  RegSrc;
   logic [1:0]  ALUControl;
   logic [3:0]  State;

   modport master (
      input  Instr, ALUFlags,
      output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
             ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, State
   );

   modport slave (
      output Instr, ALUFlags,
      input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc,
             ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, State
   );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: main FSM with memory wait counter, ALU decoder,
// conditional-execution check and the NZCV flag register.
module multicycle_controller #(
   parameter int unsigned MEM_WAIT = 0
) (
   input logic                     clk,
   input logic                     reset,
   multicycle_controller_if.master bus
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9
   } state_t;

   typedef struct packed {
      logic       adr_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
      logic [1:0] alu_control;
      logic       regw;
      logic       memw;
      logic       branch;
      logic       fetch;
      logic       flagw;
      logic       cvw;
   } ctrl_t;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

   localparam ctrl_t FETCH_CTRL = '{
      adr_src:     1'b0,
      alu_src_a:   1'b1,
      alu_src_b:   2'b10,
      result_src:  2'b10,
      alu_control: ALU_ADD,
      regw:        1'b0,
      memw:        1'b0,
      branch:      1'b0,
      fetch:       1'b1,
      flagw:       1'b0,
      cvw:         1'b0
   };

   // Instruction fields (Instr holds IR[31:12])
   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic       unused_rn;

   assign cond      = bus.Instr[19:16];
   assign op        = bus.Instr[15:14];
   assign funct     = bus.Instr[13:8];
   assign rd        = bus.Instr[3:0];
   assign unused_rn = &{1'b0, bus.Instr[7:4]};

   state_t     state, next_state;
   ctrl_t      ctrl, next_ctrl;
   logic [3:0] cnt;
   logic [3:0] flags;
   logic       last;
   logic       wait_state;
   logic       cond_ex;
   logic       next_pc;

   logic [1:0] dp_control;
   logic       dp_valid;
   logic       dp_cmp;
   logic       dp_arith;

   assign last       = (cnt == WAIT_LAST);
   assign wait_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);

   // ALU decoder for data-processing instructions
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      dp_control = ALU_ADD;
      dp_valid   = 1'b1;
      dp_cmp     = 1'b0;
      dp_arith   = 1'b1;
      case (funct[4:1])
         4'b0100: dp_control = ALU_ADD;
         4'b0010: dp_control = ALU_SUB;
         4'b0000: begin
            dp_control = ALU_AND;
            dp_arith   = 1'b0;
         end
         4'b1100: begin
            dp_control = ALU_ORR;
            dp_arith   = 1'b0;
         end
         4'b1010: begin
            dp_control = ALU_SUB;
            dp_cmp     = 1'b1;
         end
         default: begin
            dp_valid = 1'b0;
            dp_arith = 1'b0;
         end
      endcase
   end

   // Condition check against the registered NZCV flags
   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         4'b0000: cond_ex = flags[2];
         4'b0001: cond_ex = ~flags[2];
         4'b0010: cond_ex = flags[1];
         4'b0011: cond_ex = ~flags[1];
         4'b0100: cond_ex = flags[3];
         4'b0101: cond_ex = ~flags[3];
         4'b0110: cond_ex = flags[0];
         4'b0111: cond_ex = ~flags[0];
         4'b1000: cond_ex = flags[1] & ~flags[2];
         4'b1001: cond_ex = ~(flags[1] & ~flags[2]);
         4'b1010: cond_ex = (flags[3] == flags[0]);
         4'b1011: cond_ex = (flags[3] != flags[0]);
         4'b1100: cond_ex = ~flags[2] & (flags[3] == flags[0]);
         4'b1101: cond_ex = ~(~flags[2] & (flags[3] == flags[0]));
         4'b1110: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   always_comb begin
      next_state = FETCH;
      case (state)
         FETCH:    next_state = last ? DECODE : FETCH;
         DECODE: begin
            case (op)
               2'b00:   next_state = funct[5] ? EXECUTEI : EXECUTER;
               2'b01:   next_state = MEMADR;
               2'b10:   next_state = BRANCH;
               default: next_state = FETCH;
            endcase
         end
         MEMADR:   next_state = funct[0] ? MEMREAD : MEMWRITE;
         MEMREAD:  next_state = last ? MEMWB : MEMREAD;
         MEMWB:    next_state = FETCH;
         MEMWRITE: next_state = last ? FETCH : MEMWRITE;
         EXECUTER: next_state = ALUWB;
         EXECUTEI: next_state = ALUWB;
         ALUWB:    next_state = FETCH;
         BRANCH:   next_state = FETCH;
         default:  next_state = FETCH;
      endcase
   end

   // Control word for the state being entered; it is registered so outputs come straight from flops
   always_comb begin
      next_ctrl = '0;
      case (next_state)
         FETCH:  next_ctrl = FETCH_CTRL;
         DECODE: begin
            next_ctrl.alu_src_a  = 1'b1;
            next_ctrl.alu_src_b  = 2'b10;
            next_ctrl.result_src = 2'b10;
         end
         MEMADR:   next_ctrl.alu_src_b = 2'b01;
         MEMREAD:  next_ctrl.adr_src   = 1'b1;
         MEMWB: begin
            next_ctrl.result_src = 2'b01;
            next_ctrl.regw       = 1'b1;
         end
         MEMWRITE: begin
            next_ctrl.adr_src = 1'b1;
            next_ctrl.memw    = 1'b1;
         end
         EXECUTER, EXECUTEI: begin
            next_ctrl.alu_src_b   = (next_state == EXECUTEI) ? 2'b01 : 2'b00;
            next_ctrl.alu_control = dp_control;
            next_ctrl.flagw       = dp_valid;
            next_ctrl.cvw         = dp_arith;
         end
         ALUWB:    next_ctrl.regw = dp_valid & ~dp_cmp;
         BRANCH: begin
            next_ctrl.alu_src_b  = 2'b01;
            next_ctrl.result_src = 2'b10;
            next_ctrl.branch     = 1'b1;
         end
         default:  next_ctrl = FETCH_CTRL;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= FETCH;
         ctrl  <= FETCH_CTRL;
         cnt   <= 4'd0;
         flags <= 4'b0000;
      end else begin
         // NOTE: non-blocking assignments so every register here samples pre-edge values.
         state <= next_state;
         ctrl  <= next_ctrl;
         cnt   <= (wait_state && !last) ? cnt + 4'd1 : 4'd0;
         if ((state == EXECUTER || state == EXECUTEI) && ctrl.flagw && funct[0] && cond_ex) begin
            flags[3:2] <= bus.ALUFlags[3:2];
            if (ctrl.cvw) flags[1:0] <= bus.ALUFlags[1:0];
         end
      end
   end

   assign next_pc = ctrl.fetch & last;

   // FETCH's control word is the reset value, so its enables are also qualified by reset
   assign bus.IRWrite    = reset & next_pc;
   assign bus.PCWrite    = reset & (next_pc |
                                   ((ctrl.branch | (ctrl.regw & (rd == 4'hF))) & cond_ex));
   assign bus.MemWrite   = ctrl.memw & last & cond_ex;
   assign bus.RegWrite   = ctrl.regw & cond_ex;
   assign bus.AdrSrc     = ctrl.adr_src;
   assign bus.ResultSrc  = ctrl.result_src;
   assign bus.ALUSrcA    = ctrl.alu_src_a;
   assign bus.ALUSrcB    = ctrl.alu_src_b;
   assign bus.ALUControl = ctrl.alu_control;
   assign bus.ImmSrc     = op;
   assign bus.RegSrc     = {(op == 2'b01) & ~funct[0], (op == 2'b10)};
   assign bus.State      = state;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: a per-instruction reference model queues the
// expected per-cycle control outputs; a negedge monitor pops and compares them.
module tb_multicycle_controller;

   localparam int MW = 2;

   typedef struct packed {
      logic [3:0] st;
      logic       pcw;
      logic       memw;
      logic       regw;
      logic       irw;
      logic       adr;
      logic [1:0] rs;
      logic       a;
      logic [1:0] b;
      logic [1:0] imm;
      logic [1:0] regsrc;
      logic [1:0] aluc;
   } obs_t;

   logic clk;
   logic reset;
   multicycle_controller_if bus();

   multicycle_controller #(.MEM_WAIT(MW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_vec  = 0;
   int   n_miss = 0;
   int   n_cyc  = 0;
   obs_t sb[$];
   bit   mon_en = 1'b0;
   logic [3:0] mflags = 4'b0000;
   obs_t mon_act, mon_exp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ARM condition: pairs of codes share a base test, odd codes invert it; 1111 never executes
   function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v, base;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c[3:1])
         3'd0:    base = z;
         3'd1:    base = cy;
         3'd2:    base = n;
         3'd3:    base = v;
         3'd4:    base = cy && !z;
         3'd5:    base = (n == v);
         3'd6:    base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (c == 4'hF) return 1'b0;
      return c[0] ? !base : base;
   endfunction

   function automatic void dp_decode(input logic [3:0] f41, output logic [1:0] ctl,
                                     output bit valid, output bit cmp, output bit arith);
      ctl = 2'b00; valid = 1'b1; cmp = 1'b0; arith = 1'b1;
      case (f41)
         4'b0100: ctl = 2'b00;
         4'b0010: ctl = 2'b01;
         4'b0000: begin ctl = 2'b10; arith = 1'b0; end
         4'b1100: begin ctl = 2'b11; arith = 1'b0; end
         4'b1010: begin ctl = 2'b01; cmp = 1'b1; end
         default: begin valid = 1'b0; arith = 1'b0; end
      endcase
   endfunction

   function automatic logic [19:0] rand_instr();
      logic [1:0] op;
      logic [5:0] fn;
      logic [3:0] cond, rn, rd;
      logic [1:0] ctl;
      bit valid, cmp, arith;
      op   = 2'($urandom_range(0, 3));
      fn   = 6'($urandom);
      rn   = 4'($urandom);
      rd   = 4'($urandom);
      cond = ($urandom_range(0, 1) == 1) ? 4'hE : 4'($urandom_range(0, 15));
      dp_decode(fn[4:1], ctl, valid, cmp, arith);
      // flag-setting register writes stay unconditional so the write-back test is unambiguous
      if (op == 2'b00 && fn[0] && valid && !cmp) cond = 4'hE;
      return {cond, op, fn, rn, rd};
   endfunction

   // Queue the expected cycles of one instruction, then drive it into the IR slot
   task automatic issue(input logic [19:0] ins, input logic [3:0] af);
      int path[$];
      int cycles;
      logic [1:0] op, ctl;
      logic [5:0] fn;
      logic [3:0] rd;
      logic [19:0] vis;
      bit valid, cmp, arith, cx, wr, last;
      obs_t e;
      cycles = 0;
      op = ins[15:14];
      fn = ins[13:8];
      rd = ins[3:0];
      dp_decode(fn[4:1], ctl, valid, cmp, arith);
      path.push_back(0);
      path.push_back(1);
      case (op)
         2'b00: begin path.push_back(fn[5] ? 7 : 6); path.push_back(8); end
         2'b01: begin
            path.push_back(2);
            if (fn[0]) begin path.push_back(3); path.push_back(4); end
            else path.push_back(5);
         end
         2'b10: path.push_back(9);
         default: ;
      endcase
      foreach (path[k]) begin
         int s;
         int reps;
         s    = path[k];
         reps = (s == 0 || s == 3 || s == 5) ? MW + 1 : 1;
         for (int r = 0; r < reps; r++) begin
            last = (r == reps - 1);
            vis  = (s == 0) ? bus.Instr : ins;
            cx   = cond_holds(ins[19:16], mflags);
            e        = '0;
            e.st     = 4'(s);
            e.imm    = vis[15:14];
            e.regsrc = {vis[15:14] == 2'b01 && !vis[8], vis[15:14] == 2'b10};
            case (s)
               0: begin e.a = 1; e.b = 2'b10; e.rs = 2'b10; e.irw = last; e.pcw = last; end
               1: begin e.a = 1; e.b = 2'b10; e.rs = 2'b10; end
               2: e.b = 2'b01;
               3: e.adr = 1;
               4: begin e.rs = 2'b01; e.regw = cx; e.pcw = cx && rd == 4'hF; end
               5: begin e.adr = 1; e.memw = last && cx; end
               6, 7: begin e.b = (s == 7) ? 2'b01 : 2'b00; e.aluc = ctl; end
               8: begin
                  wr = valid && !cmp;
                  e.regw = wr && cx;
                  e.pcw  = wr && cx && rd == 4'hF;
               end
               9: begin e.b = 2'b01; e.rs = 2'b10; e.pcw = cx; end
               default: ;
            endcase
            sb.push_back(e);
            cycles++;
         end
         if ((s == 6 || s == 7) && valid && fn[0] && cx) begin
            mflags[3:2] = af[3:2];
            if (arith) mflags[1:0] = af[1:0];
         end
      end
      repeat (MW + 1) begin @(posedge clk); #1; end
      bus.Instr    = ins;
      bus.ALUFlags = af;
      repeat (cycles - (MW + 1)) begin @(posedge clk); #1; end
   endtask

   always @(negedge clk) begin
      if (mon_en && sb.size() > 0) begin
         mon_exp = sb.pop_front();
         mon_act = {bus.State, bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite,
                    bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc,
                    bus.RegSrc, bus.ALUControl};
         check($sformatf("cycle%0d_state%0d", n_cyc, mon_exp.st), {12'b0, mon_act},
               {12'b0, mon_exp});
         n_cyc++;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset        = 1'b0;
      bus.Instr    = 20'h00000;
      bus.ALUFlags = 4'b0000;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {28'b0, bus.State}, 32'd0);
      check("reset_enables", {28'b0, bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite}, 32'd0);
      reset  = 1'b1;
      mon_en = 1'b1;

      // directed sequence
      issue(20'hE2921, 4'b0110);   // ADDS R1,R2,#5
      issue(20'hE1510, 4'b1000);   // CMP R1,R2
      issue(20'h0A000, 4'b0000);   // BEQ, Z=0
      issue(20'hE2921, 4'b0100);   // ADDS setting Z
      issue(20'h0A000, 4'b0000);   // BEQ, Z=1
      issue(20'hE590F, 4'b0000);   // LDR R15,[R0]
      issue(20'hE5843, 4'b0000);   // STR R3,[R4,#8]
      issue(20'hEC000, 4'b0000);   // undefined Op
      issue(20'hE080F, 4'b0000);   // ADD R15,R0,R0
      issue(20'hFA000, 4'b0000);   // B with never-condition

      for (int i = 0; i < 200; i++) issue(rand_instr(), 4'($urandom));

      // reset in the middle of a store
      issue(20'hE2921, 4'b0100);
      mon_en = 1'b0;
      repeat (MW + 1) begin @(posedge clk); #1; end
      bus.Instr = 20'hE5843;
      repeat (2) begin @(posedge clk); #1; end
      check("pre_reset_state", {28'b0, bus.State}, 32'd5);
      @(posedge clk); #1;
      check("pre_reset_memwrite", {31'b0, bus.MemWrite}, 32'd0);
      #2 reset = 1'b0;
      #1;
      check("async_reset_state", {28'b0, bus.State}, 32'd0);
      check("async_reset_enables", {28'b0, bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite}, 32'd0);
      @(posedge clk); #1;
      check("held_reset_state", {28'b0, bus.State}, 32'd0);
      check("held_reset_memwrite", {31'b0, bus.MemWrite}, 32'd0);
      reset  = 1'b1;
      mflags = 4'b0000;
      mon_en = 1'b1;
      issue(20'h0A000, 4'b0000);   // BEQ after reset: flags cleared, not taken
      for (int i = 0; i < 10; i++) issue(rand_instr(), 4'($urandom));

      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
